// File: rtl/l2_line_responder.sv
// Responder side of the cache-to-L2 line protocol: 4-beat fills and writebacks
// served from a word-addressed backing store, with programmable read latency.
module l2_line_responder #(
   parameter int unsigned WORDS_PER_LINE  = 4,
   parameter int unsigned MEM_DEPTH_WORDS = 4096,
   parameter int unsigned READ_LATENCY    = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WRITE,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] WR_DATA,
   input  logic        WR_VALID,
   output logic        WR_READY,
   output logic [31:0] RD_DATA,
   output logic        RD_VALID,
   output logic        RD_LAST,
   output logic        WR_DONE,
   output logic        ERR
);

   localparam int unsigned AW        = $clog2(MEM_DEPTH_WORDS);
   localparam logic [1:0]  LAST_BEAT = 2'(WORDS_PER_LINE - 1);
   localparam logic [3:0]  LAT_LOAD  = 4'(READ_LATENCY - 1);

   typedef enum logic [2:0] {IDLE, LAT, RD_BURST, WR_BURST, WR_RESP} state_t;

   state_t      state;
   logic [27:0] line;
   logic [1:0]  beat;
   logic [3:0]  lat_cnt;
   logic        line_oor;
   logic [1:0]  fetch_beat;
   logic [AW-1:0] fetch_idx;
   logic [AW-1:0] wr_idx;
   logic [31:0] rd_word;
   logic        mem_we;
   logic        unused_addr_bits;

   logic [31:0] mem [MEM_DEPTH_WORDS];

   assign unused_addr_bits = ^REQ_ADDR[3:0];

   // Range check on the full-width word index; truncation to AW happens only afterwards.
   assign line_oor   = {1'b0, line, 2'b00} >= 31'(MEM_DEPTH_WORDS);
   // Output registers lead the beat counter by one word during a fill.
   assign fetch_beat = (state == RD_BURST) ? beat + 2'd1 : beat;
   assign fetch_idx  = AW'({line, fetch_beat});
   assign wr_idx     = AW'({line, beat});
   assign rd_word    = line_oor ? '0 : mem[fetch_idx];
   assign mem_we     = (state == WR_BURST) && WR_VALID && !line_oor;

   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[wr_idx] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         line      <= '0;
         beat      <= '0;
         lat_cnt   <= '0;
         REQ_READY <= 1'b0;
         WR_READY  <= 1'b0;
         RD_DATA   <= '0;
         RD_VALID  <= 1'b0;
         RD_LAST   <= 1'b0;
         WR_DONE   <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (REQ_VALID && REQ_READY) begin
                  line      <= REQ_ADDR[31:4];
                  beat      <= '0;
                  REQ_READY <= 1'b0;
                  if (REQ_WRITE) begin
                     state    <= WR_BURST;
                     WR_READY <= 1'b1;
                  end else begin
                     state   <= LAT;
                     lat_cnt <= LAT_LOAD;
                  end
               end else begin
                  REQ_READY <= 1'b1;
               end
            end
            LAT: begin
               if (lat_cnt == '0) begin
                  state    <= RD_BURST;
                  RD_VALID <= 1'b1;
                  RD_DATA  <= rd_word;
                  RD_LAST  <= (LAST_BEAT == 2'd0);
                  ERR      <= (LAST_BEAT == 2'd0) && line_oor;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            RD_BURST: begin
               if (beat == LAST_BEAT) begin
                  state     <= IDLE;
                  RD_VALID  <= 1'b0;
                  RD_LAST   <= 1'b0;
                  RD_DATA   <= '0;
                  ERR       <= 1'b0;
                  REQ_READY <= 1'b1;
               end else begin
                  beat    <= beat + 2'd1;
                  RD_DATA <= rd_word;
                  RD_LAST <= (beat + 2'd1 == LAST_BEAT);
                  ERR     <= (beat + 2'd1 == LAST_BEAT) && line_oor;
               end
            end
            WR_BURST: begin
               if (WR_VALID) begin
                  beat <= beat + 2'd1;
                  if (beat == LAST_BEAT) begin
                     state    <= WR_RESP;
                     WR_READY <= 1'b0;
                     WR_DONE  <= 1'b1;
                     ERR      <= line_oor;
                  end
               end
            end
            WR_RESP: begin
               state     <= IDLE;
               WR_DONE   <= 1'b0;
               ERR       <= 1'b0;
               REQ_READY <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
